// File: rtl/div_pkg.sv
// div_pkg: shared widths, entry layout and result record for the divider result path
package div_pkg;
    localparam int DIV_WIDTH     = 10;
    localparam int DIV_ENTRY_W   = DIV_WIDTH + 2;
    localparam int ENTRY_DVZ_BIT = DIV_WIDTH;
    localparam int ENTRY_OVF_BIT = DIV_WIDTH + 1;
    typedef struct packed {
        logic                 ovf;
        logic                 dvz;
        logic [DIV_WIDTH-1:0] q;
    } div_result_t;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-DEPTH pointer with sync reset and increment enable
// Ports: clock, reset (sync, active-high), inc (advance), ptr (0..DEPTH-1)
module wrap_counter #(
    parameter int DEPTH = 4,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clock)
        ptr <= reset ? '0 : inc ? (ptr == W'(DEPTH - 1) ? '0 : ptr + 1'b1) : ptr;
endmodule

// File: rtl/div_result_fifo.sv
// div_result_fifo: FWFT FIFO buffering divider results {ovf, dvz, q} for a valid/ready consumer
// Ports: clock, reset (sync, active-high flush); res_valid/res_q/res_dvz/res_ovf in, res_ready out;
//        out_valid/out_q/out_dvz/out_ovf out, out_ready in; count/full/empty status; sticky overrun.
// Optional: define DIV_RESULT_SAT_EN to saturate the stored quotient to all-ones on overflow.
module div_result_fifo
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_q,
    input  logic             res_dvz,
    input  logic             res_ovf,
    output logic             res_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_dvz,
    output logic             out_ovf,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overrun
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH+1:0] mem [DEPTH];
    logic [WIDTH+1:0] head;
    logic [WIDTH-1:0] q_in;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;
    assign full      = count == CNT_W'(DEPTH);
    assign empty     = count == '0;
    assign res_ready = ~full;
    assign out_valid = ~empty;
    assign push      = res_valid & ~full;
    assign pop       = out_valid & out_ready;
`ifdef DIV_RESULT_SAT_EN
    assign q_in = res_dvz ? '0 : res_ovf ? '1 : res_q;
`else
    assign q_in = res_dvz ? '0 : res_q;
`endif
    // an empty FIFO shows zeros instead of stale storage
    assign head    = empty ? '0 : mem[rd_ptr];
    assign out_q   = head[WIDTH-1:0];
    assign out_dvz = head[WIDTH];
    assign out_ovf = head[WIDTH+1];
    wrap_counter #(.DEPTH(DEPTH), .W(PW)) u_wr (.clock(clock), .reset(reset), .inc(push), .ptr(wr_ptr));
    wrap_counter #(.DEPTH(DEPTH), .W(PW)) u_rd (.clock(clock), .reset(reset), .inc(pop), .ptr(rd_ptr));
    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr] <= {res_ovf & ~res_dvz, res_dvz, q_in};
        count   <= reset ? '0 : count + CNT_W'(push) - CNT_W'(pop);
        overrun <= reset ? 1'b0 : overrun | (res_valid & full);
    end
endmodule

// File: tb/tb_div_result_fifo.sv
module tb_div_result_fifo;
    logic       clock = 0, reset = 0, res_valid = 0, res_dvz = 0, res_ovf = 0, out_ready = 0;
    logic [9:0] res_q = 0;
    logic       res_ready, out_valid, out_dvz, out_ovf, full, empty, overrun;
    logic [9:0] out_q;
    logic [2:0] count;
    int ntot = 0, nbad = 0;
    logic [11:0] mq[$];
    logic        movr = 0;

    always #5 clock = ~clock;

    div_result_fifo dut (
        .clock(clock), .reset(reset), .res_valid(res_valid), .res_q(res_q), .res_dvz(res_dvz),
        .res_ovf(res_ovf), .res_ready(res_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_dvz(out_dvz), .out_ovf(out_ovf), .count(count), .full(full),
        .empty(empty), .overrun(overrun)
    );

    function automatic logic [11:0] ref_entry(logic [9:0] q, logic dvz, logic ovf);
        if (dvz) return {2'b01, 10'd0};
`ifdef DIV_RESULT_SAT_EN
        if (ovf) return {2'b10, 10'h3FF};
`endif
        return {ovf, 1'b0, q};
    endfunction

    function automatic logic [11:0] ref_head();
        return mq.size() > 0 ? mq[0] : 12'd0;
    endfunction

    task automatic cyc();
        bit f;
        f = mq.size() == 4;
        if (reset) begin
            mq.delete();
            movr = 0;
        end else begin
            if (res_valid && f) movr = 1;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (res_valid && !f) mq.push_back(ref_entry(res_q, res_dvz, res_ovf));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        res_valid = 0; out_ready = 0; res_dvz = 0; res_ovf = 0;
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic push(logic [9:0] q, logic dvz, logic ovf);
        res_valid = 1; res_q = q; res_dvz = dvz; res_ovf = ovf;
        cyc();
        res_valid = 0; res_dvz = 0; res_ovf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc();
        ntot++; if (empty !== 1'b1) begin nbad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        ntot++; if (full !== 1'b0) begin nbad++; $display("FAIL reset_full got=%b exp=0", full); end
        ntot++; if (count !== 3'd0) begin nbad++; $display("FAIL reset_count got=%0d exp=0", count); end
        ntot++; if (res_ready !== 1'b1) begin nbad++; $display("FAIL reset_res_ready got=%b exp=1", res_ready); end
        ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        ntot++; if (overrun !== 1'b0) begin nbad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        ntot++; if ({out_ovf, out_dvz, out_q} !== 12'd0) begin nbad++; $display("FAIL reset_out got=%h exp=0", {out_ovf, out_dvz, out_q}); end
    endtask

    task automatic test_single();
        do_reset();
        push(10'd37, 0, 0);
        ntot++; if (out_valid !== 1'b1) begin nbad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        ntot++; if (out_q !== 10'd37) begin nbad++; $display("FAIL single_q got=%0d exp=37", out_q); end
        ntot++; if (count !== 3'd1) begin nbad++; $display("FAIL single_count got=%0d exp=1", count); end
        out_ready = 1;
        cyc();
        out_ready = 0;
        ntot++; if (empty !== 1'b1) begin nbad++; $display("FAIL single_empty got=%b exp=1", empty); end
        ntot++; if (out_q !== 10'd0) begin nbad++; $display("FAIL single_out_zero got=%0d exp=0", out_q); end
    endtask

    task automatic test_full_overrun();
        do_reset();
        for (int i = 1; i <= 4; i++) push(10'(i), 0, 0);
        ntot++; if (full !== 1'b1) begin nbad++; $display("FAIL full_flag got=%b exp=1", full); end
        ntot++; if (res_ready !== 1'b0) begin nbad++; $display("FAIL full_res_ready got=%b exp=0", res_ready); end
        push(10'd5, 0, 0);
        ntot++; if (overrun !== 1'b1) begin nbad++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        ntot++; if (count !== 3'd4) begin nbad++; $display("FAIL overrun_count got=%0d exp=4", count); end
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            ntot++; if (out_q !== 10'(i)) begin nbad++; $display("FAIL drain_order got=%0d exp=%0d", out_q, i); end
            cyc();
        end
        out_ready = 0;
        ntot++; if (empty !== 1'b1) begin nbad++; $display("FAIL drain_empty got=%b exp=1", empty); end
        ntot++; if (overrun !== 1'b1) begin nbad++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_full_pop_push();
        do_reset();
        for (int i = 11; i <= 14; i++) push(10'(i), 0, 0);
        out_ready = 1;
        push(10'd9, 0, 0);
        out_ready = 0;
        ntot++; if (count !== 3'd3) begin nbad++; $display("FAIL fullpp_count got=%0d exp=3", count); end
        ntot++; if (overrun !== 1'b1) begin nbad++; $display("FAIL fullpp_overrun got=%b exp=1", overrun); end
        ntot++; if (out_q !== 10'd12) begin nbad++; $display("FAIL fullpp_head got=%0d exp=12", out_q); end
        for (int i = 0; i < 60; i++) begin
            res_valid = 1'($urandom_range(0, 1));
            res_q = 10'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            ntot++;
            if ({out_valid, out_ovf, out_dvz, out_q, count} !== {mq.size() > 0, ref_head(), 3'(mq.size())}) begin
                nbad++;
                $display("FAIL wrap_stream got=%b/%h/%0d exp=%b/%h/%0d", out_valid, {out_ovf, out_dvz, out_q}, count,
                         mq.size() > 0, ref_head(), mq.size());
            end
        end
        res_valid = 0; out_ready = 0;
    endtask

    task automatic test_flags();
        logic [9:0] exp_q;
        do_reset();
        push(10'h155, 1, 1);
        ntot++; if ({out_ovf, out_dvz, out_q} !== {2'b01, 10'd0}) begin nbad++; $display("FAIL dvz_entry got=%h exp=%h", {out_ovf, out_dvz, out_q}, {2'b01, 10'd0}); end
        out_ready = 1;
        cyc();
        out_ready = 0;
`ifdef DIV_RESULT_SAT_EN
        exp_q = 10'h3FF;
`else
        exp_q = 10'h012;
`endif
        push(10'h012, 0, 1);
        ntot++; if (out_q !== exp_q) begin nbad++; $display("FAIL ovf_q got=%h exp=%h", out_q, exp_q); end
        ntot++; if ({out_ovf, out_dvz} !== 2'b10) begin nbad++; $display("FAIL ovf_flags got=%b exp=10", {out_ovf, out_dvz}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push(10'(20 + i), 0, 0);
        out_ready = 1;
        cyc();
        out_ready = 0;
        ntot++; if ({count, overrun} !== {3'd3, 1'b1}) begin nbad++; $display("FAIL mid_pre got=%0d/%b exp=3/1", count, overrun); end
        reset = 1;
        push(10'd99, 0, 0);
        reset = 0;
        ntot++; if (count !== 3'd0) begin nbad++; $display("FAIL mid_count got=%0d exp=0", count); end
        ntot++; if (empty !== 1'b1) begin nbad++; $display("FAIL mid_empty got=%b exp=1", empty); end
        ntot++; if (overrun !== 1'b0) begin nbad++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
        ntot++; if (out_valid !== 1'b0) begin nbad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            res_valid = 1'($urandom_range(0, 3) != 0);
            res_q = 10'($urandom);
            res_dvz = 1'($urandom_range(0, 5) == 0);
            res_ovf = 1'($urandom_range(0, 3) == 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            cyc();
            ntot++;
            if ({out_valid, out_ovf, out_dvz, out_q, count, full, empty, res_ready, overrun} !==
                {mq.size() > 0, ref_head(), 3'(mq.size()), mq.size() == 4, mq.size() == 0, mq.size() != 4, movr}) begin
                nbad++;
                $display("FAIL random got=%b/%h/%0d/%b%b%b/%b exp=%b/%h/%0d/%b", out_valid, {out_ovf, out_dvz, out_q},
                         count, full, empty, res_ready, overrun, mq.size() > 0, ref_head(), mq.size(), movr);
            end
        end
        res_valid = 0; out_ready = 0; res_dvz = 0; res_ovf = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_overrun();
        test_full_pop_push();
        test_flags();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
